fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/sisc_pkg.sv | 34 +++
 rtl/fetch_unit_pc_next.sv | 20 ++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: widths, opcodes, addressing modes and the fetch
// FSM state encoding.
package sisc_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 4;

    localparam logic [OP_W-1:0] NOOP = 4'd0;
    localparam logic [OP_W-1:0] LOD  = 4'd1;
    localparam logic [OP_W-1:0] STR  = 4'd2;
    localparam logic [OP_W-1:0] ADD  = 4'd3;
    localparam logic [OP_W-1:0] SUB  = 4'd4;
    localparam logic [OP_W-1:0] AND  = 4'd5;
    localparam logic [OP_W-1:0] OR   = 4'd6;
    localparam logic [OP_W-1:0] XOR  = 4'd7;
    localparam logic [OP_W-1:0] NOT  = 4'd8;
    localparam logic [OP_W-1:0] SHL  = 4'd9;
    localparam logic [OP_W-1:0] SHR  = 4'd10;
    localparam logic [OP_W-1:0] BRA  = 4'd11;
    localparam logic [OP_W-1:0] BRZ  = 4'd12;
    localparam logic [OP_W-1:0] BRN  = 4'd13;
    localparam logic [OP_W-1:0] BRC  = 4'd14;
    localparam logic [OP_W-1:0] HLT  = 4'd15;

    localparam logic [OP_W-1:0] AM_IMM = 4'd8;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_BUF  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: sequential increment, absolute target or pc-relative
// target, all modulo 2^16.
module pc_next
    import sisc_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] imm,
    input  logic            pc_sel,
    input  logic            br_sel,
    output logic [PC_W-1:0] next_pc_c
);

    always_comb begin
        next_pc_c = pc + PC_W'(1);
        if (pc_sel) begin
            next_pc_c = br_sel ? imm : pc + imm;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-entry prefetch buffer filled from instruction
// memory, and the instruction register loaded on demand from the buffer.
module fetch_unit
    import sisc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [15:0]        imm,
    output logic               ir_valid,
    output logic               stall
);

    fetch_state_t       state;
    logic [INSTR_W-1:0] buffer;
    logic [PC_W-1:0]    pc_new;
    logic               load_ok;
    logic               pc_ok;

    assign opcode = instr[31:28];
    assign mm     = instr[27:24];
    assign imm    = instr[15:0];

    pc_next u_pc_next (
        .pc        (pc),
        .imm       (imm),
        .pc_sel    (pc_sel),
        .br_sel    (br_sel),
        .next_pc_c (pc_new)
    );

    // The buffer is valid exactly when the FSM sits in FS_BUF.
    assign stall   = !rst && ir_load && (state != FS_BUF);
    assign load_ok = ir_load && (state == FS_BUF);
    assign pc_ok   = pc_write && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FS_IDLE;
            buffer   <= '0;
            pc       <= '0;
            instr    <= '0;
            ir_valid <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (pc_rst) begin
            state    <= FS_IDLE;
            pc       <= '0;
            instr    <= {NOOP, 28'd0};
            ir_valid <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            if (load_ok) begin
                instr    <= buffer;
                ir_valid <= 1'b1;
            end
            // An accepted PC update wins over everything, dropping any ack.
            if (pc_ok) begin
                pc       <= pc_new;
                state    <= FS_REQ;
                mem_req  <= 1'b1;
                mem_addr <= pc_new;
            end else begin
                case (state)
                    FS_IDLE: begin
                        state    <= FS_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                    FS_REQ: begin
                        if (mem_ack) begin
                            buffer  <= mem_rdata;
                            state   <= FS_BUF;
                            mem_req <= 1'b0;
                        end
                    end
                    FS_BUF: begin
                        // Consumed without a PC move: refetch the word at pc.
                        if (load_ok) begin
                            state    <= FS_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                        end
                    end
                    default: begin
                        state   <= FS_IDLE;
                        mem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic against a buffer/request-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0;
    logic        ir_load = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr, pc, imm;
    logic [31:0] instr;
    logic [3:0]  opcode, mm;
    logic        ir_valid, stall;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc_rst(pc_rst), .pc_write(pc_write),
        .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_addr(mem_addr), .pc(pc), .instr(instr), .opcode(opcode),
        .mm(mm), .imm(imm), .ir_valid(ir_valid), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pc, IR, one-word buffer, outstanding request.
    logic [15:0] m_pc = '0, m_addr = '0;
    logic [31:0] m_instr = '0, m_buf = '0;
    logic        m_irv = 1'b0, m_bufv = 1'b0, m_req = 1'b0, m_boot = 1'b1;

    // Memory responder configuration.
    logic [31:0] word_q[$];
    int          wait_cnt = 0;
    logic        rand_delay = 1'b0;
    logic        spurious = 1'b0;
    logic        last_stall, last_ack;
    logic [15:0] last_ack_addr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_instr = '0; m_irv = 1'b0; m_bufv = 1'b0;
        m_req = 1'b0; m_boot = 1'b1; m_addr = '0;
    endtask

    task automatic check_outputs();
        check("pc", 32'(pc), 32'(m_pc));
        check("instr", instr, m_instr);
        check("opcode", 32'(opcode), 32'(m_instr[31:28]));
        check("mm", 32'(mm), 32'(m_instr[27:24]));
        check("imm", 32'(imm), 32'(m_instr[15:0]));
        check("ir_valid", 32'(ir_valid), 32'(m_irv));
        check("mem_req", 32'(mem_req), 32'(m_req));
        if (m_req) check("mem_addr", 32'(mem_addr), 32'(m_addr));
    endtask

    // One clock: drive at negedge, check stall, step model at posedge, check.
    task automatic cycle(input logic l, input logic w, input logic ps,
                         input logic bs, input logic pr);
        logic [15:0] npc;
        logic        st, acc, ld;
        ir_load = l; pc_write = w; pc_sel = ps; br_sel = bs; pc_rst = pr;
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wait_cnt == 0) begin
                mem_ack = 1'b1;
                if (word_q.size() > 0) mem_rdata = word_q.pop_front();
                else mem_rdata = $urandom;
                wait_cnt = rand_delay ? int'($urandom_range(0, 3)) : 0;
            end else begin
                wait_cnt--;
            end
        end else if (spurious && $urandom_range(0, 7) == 0) begin
            mem_ack = 1'b1;
            mem_rdata = $urandom;
        end
        last_ack = mem_ack;
        last_ack_addr = mem_addr;
        #1;
        st = l && !m_bufv;
        last_stall = stall;
        check("stall", 32'(stall), 32'(st));
        @(posedge clk);
        if (pr) begin
            model_reset();
        end else begin
            acc = w && !st;
            ld  = l && m_bufv;
            if (!ps) npc = m_pc + 16'd1;
            else if (bs) npc = m_instr[15:0];
            else npc = m_pc + m_instr[15:0];
            if (ld) begin
                m_instr = m_buf;
                m_irv = 1'b1;
            end
            if (acc) begin
                m_pc = npc; m_bufv = 1'b0; m_req = 1'b1; m_addr = npc; m_boot = 1'b0;
            end else if (m_boot) begin
                m_boot = 1'b0; m_req = 1'b1; m_addr = m_pc;
            end else if (m_req && mem_ack) begin
                m_bufv = 1'b1; m_buf = mem_rdata; m_req = 1'b0;
            end else if (ld) begin
                m_bufv = 1'b0; m_req = 1'b1; m_addr = m_pc;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        ir_load = 1'b1; pc_write = 1'b0; pc_rst = 1'b0; mem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_irv", 32'(ir_valid), 32'h0);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_stall_hold", 32'(stall), 32'h0);
        rst = 1'b0;
        ir_load = 1'b0;
        model_reset();
    endtask

    task automatic wait_buf();
        for (int i = 0; i < 40 && !m_bufv; i++) cycle(0, 0, 0, 0, 0);
        check("wait_buf_timeout", 32'(m_bufv), 32'h1);
    endtask

    // Bring a chosen word into the IR with ir_load alone (pc unchanged).
    task automatic set_ir(input logic [31:0] word);
        word_q.delete();
        word_q.push_back(word);
        for (int i = 0; i < 40; i++) begin
            if (m_bufv && m_buf == word) break;
            if (m_bufv) cycle(1, 0, 0, 0, 0);
            else cycle(0, 0, 0, 0, 0);
        end
        check("set_ir_timeout", m_buf, word);
        cycle(1, 0, 0, 0, 0);
    endtask

    task automatic branch_abs(input logic [15:0] target);
        set_ir({4'hB, 4'h8, 8'h00, target});
        cycle(0, 1, 1, 1, 0);
        check("abs_pc", 32'(pc), 32'(target));
    endtask

    localparam logic [31:0] MARK = 32'hDEAD_0031;

    initial begin
        int nstall;
        @(negedge clk);
        // Reset and boot from address 0.
        word_q.push_back(32'h1800_0005);
        wait_cnt = 0;
        do_reset();
        cycle(0, 0, 0, 0, 0);
        check("boot_req", 32'(mem_req), 32'h1);
        check("boot_addr", 32'(mem_addr), 32'h0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        check("boot_opcode", 32'(opcode), 32'h1);
        check("boot_mm", 32'(mm), 32'h8);
        check("boot_imm", 32'(imm), 32'h5);
        check("boot_pc", 32'(pc), 32'h1);

        // Sequential fetch at 0x0010.
        branch_abs(16'h0010);
        wait_buf();
        cycle(1, 1, 0, 0, 0);
        check("seq_pc", 32'(pc), 32'h11);
        check("seq_addr", 32'(mem_addr), 32'h11);

        // Relative branch 0x0020 + 0xFFF0.
        branch_abs(16'h0020);
        set_ir(32'hB000_FFF0);
        cycle(0, 1, 1, 0, 0);
        check("rel_pc", 32'(pc), 32'h10);

        // Absolute branch flushes and requests the target.
        branch_abs(16'h0100);
        check("abs_req", 32'(mem_req), 32'h1);
        check("abs_addr", 32'(mem_addr), 32'h100);

        // Stall while memory is slow, ir_load held.
        branch_abs(16'h0050);
        wait_cnt = 2;
        nstall = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, 0, 0);
            if (!last_stall) break;
            nstall++;
        end
        check("stall_cycles", 32'(nstall), 32'd3);
        check("stall_pc_after", 32'(pc), 32'h51);

        // Branch colliding with the ack for 0x0031.
        branch_abs(16'h0030);
        set_ir(32'h1800_0040);
        word_q.delete();
        word_q.push_back(MARK);
        wait_cnt = 1;
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 1, 0);
        check("coll_ack", 32'(last_ack), 32'h1);
        check("coll_ack_addr", 32'(last_ack_addr), 32'h31);
        check("coll_next_addr", 32'(mem_addr), 32'h40);
        wait_buf();
        cycle(1, 0, 0, 0, 0);
        check("coll_no_mark", 32'(instr == MARK), 32'h0);

        // PC wrap.
        branch_abs(16'hFFFF);
        cycle(0, 1, 0, 0, 0);
        check("wrap_pc", 32'(pc), 32'h0);

        // pc_rst while a request is outstanding.
        wait_cnt = 3;
        check("prst_in_req", 32'(mem_req), 32'h1);
        cycle(0, 0, 0, 0, 1);
        check("prst_req", 32'(mem_req), 32'h0);
        check("prst_instr", instr, 32'h0);
        check("prst_irv", 32'(ir_valid), 32'h0);

        // Random traffic with random latency, stray acks and mid-run resets.
        rand_delay = 1'b1;
        spurious = 1'b1;
        word_q.delete();
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) do_reset();
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  1'($urandom), 1'($urandom), $urandom_range(0, 63) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
